// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus between the issuing datapath and seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, trial subtract built
// from a ripple chain of 4-bit adder slices, sign fix-up in a final cycle.
module seq_divider_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;

    always_comb begin
        c[0] = c_i;
        for (int k = 0; k < 4; k++) begin
            s_o[k]   = a_i[k] ^ b_i[k] ^ c[k];
            c[k + 1] = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
        end
        c_o = c[4];
    end
endmodule

module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int NSL = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes the quotient as bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgnq_q, sgnq_d, sgnr_q, sgnr_d, dz_q, dz_d;
    logic             done_q, done_d, dzo_q, dzo_d;

    // Partial remainder after the shift is WIDTH+1 bits; its top bit joins the slice carry below.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic [NSL:0]     carry;
    logic             no_borrow;

    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NSL; g++) begin : g_slice
        seq_divider_slice u_slice (
            .a_i (shifted[4*g +: 4]),
            .b_i (~dvs_q[4*g +: 4]),
            .c_i (carry[g]),
            .s_o (trial[4*g +: 4]),
            .c_o (carry[g+1])
        );
    end

    assign no_borrow = shifted[WIDTH] | carry[NSL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ITER;
            ITER:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        cnt_d  = cnt_q;
        sgnq_d = sgnq_q;
        sgnr_d = sgnr_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        dzo_d  = dzo_q;
        case (state_q)
            IDLE: if (bus.start) begin
                sgnq_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                sgnr_d = bus.is_signed & bus.dividend[WIDTH-1];
                dvd_d  = (bus.is_signed & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                dvs_d  = (bus.is_signed & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                dz_d   = (bus.divisor == '0);
                rem_d  = '0;
                cnt_d  = '0;
            end
            ITER: begin
                rem_d = no_borrow ? trial : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
            end
            FIX: begin
                // Divide-by-zero forces an all-ones quotient regardless of the sign fix-up.
                quo_d  = dz_q ? '1 : (sgnq_q ? -dvd_q : dvd_q);
                rmd_d  = sgnr_q ? -rem_q : rem_q;
                done_d = 1'b1;
                dzo_d  = dz_q;
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = dzo_q;
endmodule
